// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings, FSM
// state type, byte-lane mask width and the request legality / store lane
// helper functions used by lsu_ctrl.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = 4;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    // Store encodings
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        StIdle,
        StLdAddr,
        StLdData,
        StStEn,
        StStHold,
        StResp
    } lsu_state_e;

    // Request is illegal: not exactly one of load/store, unknown funct3, or
    // address not naturally aligned for the access size.
    function automatic logic req_illegal(input logic       load,
                                         input logic       store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        if (load == store) begin
            bad = 1'b1;
        end else if (load) begin
            case (funct3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = offset[0];
                F3_LW:         bad = |offset;
                default:       bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = offset[0];
                F3_SW:   bad = |offset;
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [MASK_W-1:0] store_mask(input logic [2:0] funct3,
                                                     input logic [1:0] offset);
        case (funct3)
            F3_SB:   return 4'b0001 << offset;
            F3_SH:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the source so every enabled lane already holds the right bytes.
    function automatic logic [WORD_W-1:0] store_data(input logic [2:0]        funct3,
                                                     input logic [WORD_W-1:0] wdata);
        case (funct3)
            F3_SB:   return {4{wdata[7:0]}};
            F3_SH:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: picks the byte/half lane out of a memory word and
// sign- or zero-extends it according to funct3.
//   i_word    memory read word
//   i_offset  byte offset within the word (addr[1:0])
//   i_funct3  LB/LH/LW/LBU/LHU
//   o_result  extended load value
module lsu_load_fmt
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        unique case (i_offset)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_LB:   o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   o_result = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LBU:  o_result = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  o_result = {{(XLEN-16){1'b0}}, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller between execute and data memory.
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_req_*/o_req_ready               request handshake (load/store, funct3, addr, wdata)
//   o_mem_raddr, i_mem_rdata          word-aligned read port, data one cycle later
//   o_mem_wen/waddr/wdata/wmask       write port, strobe one cycle, held one more
//   o_resp_valid/i_resp_ready         response handshake
//   o_resp_rdata, o_resp_err          extended load data, misalign/illegal flag
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_load,
    input  logic              i_req_store,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic [ADDR_W-1:0] o_mem_raddr,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [MASK_W-1:0] o_mem_wmask,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [XLEN-1:0]   o_resp_rdata,
    output logic              o_resp_err
);

    lsu_state_e        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_mem_wen;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;

    logic              w_accept;
    logic              w_req_err;
    logic [XLEN-1:0]   w_load_data;

    assign o_req_ready = (r_state == StIdle) && !i_rst;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_req_err   = req_illegal(i_req_load, i_req_store, i_req_funct3, i_req_addr[1:0]);

    // Request latches carry no reset: a write strobed just before a reset
    // must still commit with its original address, data and mask.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_addr   <= i_req_addr;
            r_funct3 <= i_req_funct3;
            r_wdata  <= store_data(i_req_funct3, i_req_wdata);
            r_wmask  <= store_mask(i_req_funct3, i_req_addr[1:0]);
        end
    end

    lsu_load_fmt #(
        .XLEN (XLEN)
    ) u_load_fmt (
        .i_word   (i_mem_rdata),
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_result (w_load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_mem_wen    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        if (w_req_err) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                        end else if (i_req_load) begin
                            r_state <= StLdAddr;
                        end else begin
                            r_state   <= StStEn;
                            r_mem_wen <= 1'b1;
                        end
                    end
                end
                StLdAddr: r_state <= StLdData;
                StLdData: begin
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                    r_resp_err   <= 1'b0;
                end
                StStEn: begin
                    r_state   <= StStHold;
                    r_mem_wen <= 1'b0;
                end
                StStHold: begin
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end
                StResp: begin
                    if (i_resp_ready) begin
                        r_state      <= StIdle;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_mem_raddr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_mem_waddr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_mem_wdata  = r_wdata;
    assign o_mem_wmask  = r_wmask;
    assign o_mem_wen    = r_mem_wen;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized loads and
// stores checked against a byte-level memory reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .XLEN   (32),
        .ADDR_W (32)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_load   (req_load),
        .i_req_store  (req_store),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_mem_raddr  (mem_raddr),
        .i_mem_rdata  (mem_rdata),
        .o_mem_wen    (mem_wen),
        .o_mem_waddr  (mem_waddr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wmask  (mem_wmask),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err)
    );

    // Memory: synchronous read, write committed one edge after the strobe
    // using the address/data/mask still held on the port.
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        wen_seen = 1'b0;
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx;
    logic [31:0] poke_val;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_raddr[5:2]];
        wen_seen  <= mem_wen;
        if (poke_en) mem[poke_idx] <= poke_val;
        if (wen_seen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_err(input bit ld, input bit st, input logic [2:0] f3,
                                     input logic [31:0] a);
        if (ld == st) return 1'b1;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (st && f3 > 3'd2) return 1'b1;
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        int     n;
        int     off;
        n   = nbytes(f3);
        off = int'(a % 4);
        v   = longint'(ref_mem[a[5:2]] >> (8 * off));
        if (n < 4) begin
            v = v % (longint'(1) << (8 * n));
            if (f3 < 3'd4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        end
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        int off;
        off = int'(a % 4);
        for (int b = 0; b < nbytes(f3); b++)
            ref_mem[a[5:2]][8*(off+b) +: 8] = wd[8*b +: 8];
    endtask

    task automatic exp_lanes(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] ew, output logic [3:0] em);
        int n;
        int off;
        n   = nbytes(f3);
        off = int'(a % 4);
        for (int l = 0; l < 4; l++) begin
            ew[8*l +: 8] = wd[8*(l % n) +: 8];
            em[l]        = (l >= off) && (l < off + n);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(negedge clk);
        poke_en      = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One complete request/response transaction with a response stall.
    task automatic run_req(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int stall);
        bit          e_err;
        logic [31:0] e_rd;
        logic [31:0] e_wd;
        logic [3:0]  e_wm;
        int          e_lat;
        int          e_wen;
        int          lat;
        int          wen_cnt;
        e_err = model_err(ld, st, f3, a);
        e_rd  = (ld && !e_err) ? model_load(f3, a) : 32'h0;
        e_lat = e_err ? 1 : 3;
        e_wen = (st && !e_err) ? 1 : 0;
        exp_lanes(f3, a, wd, e_wd, e_wm);

        @(negedge clk);
        chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 0;
        wen_cnt   = 0;
        for (int k = 1; k <= 10; k++) begin
            if (mem_wen === 1'b1) wen_cnt++;
            if (k == 1 && ld && !e_err) chk({tag, " raddr"}, mem_raddr, {a[31:2], 2'b00});
            if ((k == 1 || k == 2) && e_wen == 1) begin
                chk({tag, " waddr"}, mem_waddr, {a[31:2], 2'b00});
                chk({tag, " wdata"}, mem_wdata, e_wd);
                chk({tag, " wmask"}, 32'(mem_wmask), 32'(e_wm));
            end
            if (resp_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " wen pulses"}, 32'(wen_cnt), 32'(e_wen));
        chk({tag, " err"}, 32'(resp_err), 32'(e_err));
        chk({tag, " rdata"}, resp_rdata, e_rd);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, " stall valid"}, 32'(resp_valid), 32'd1);
            chk({tag, " stall rdata"}, resp_rdata, e_rd);
            chk({tag, " stall err"}, 32'(resp_err), 32'(e_err));
            chk({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " valid dropped"}, 32'(resp_valid), 32'd0);
        chk({tag, " back to idle"}, 32'(req_ready), 32'd1);
        if (e_wen == 1) model_store(f3, a, wd);
    endtask

    initial begin
        logic [31:0] e_wd;
        logic [3:0]  e_wm;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        bit          ld;
        bit          st;
        int          r;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        for (int i = 0; i < 16; i++) poke(4'(i), $urandom);

        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset mem_wen", 32'(mem_wen), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);

        // Directed loads
        poke(4'd4, 32'hDEAD_BEEF);
        run_req("lw", 1, 0, 3'd2, 32'h8000_0010, 32'h0, 0);
        chk("lw constant", model_load(3'd2, 32'h8000_0010), 32'hDEAD_BEEF);
        poke(4'd4, 32'h80FF_0000);
        run_req("lb", 1, 0, 3'd0, 32'h8000_0013, 32'h0, 0);
        run_req("lbu", 1, 0, 3'd4, 32'h8000_0013, 32'h0, 1);
        run_req("lh", 1, 0, 3'd1, 32'h8000_0012, 32'h0, 0);
        run_req("lhu", 1, 0, 3'd5, 32'h8000_0012, 32'h0, 0);

        // Directed store, then read back
        run_req("sh", 0, 1, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 0);
        run_req("sh readback", 1, 0, 3'd2, 32'h8000_0000, 32'h0, 0);

        // Errors
        run_req("lw misalign", 1, 0, 3'd2, 32'h8000_0001, 32'h0, 0);
        run_req("sh misalign", 0, 1, 3'd1, 32'h8000_0003, 32'h5555_5555, 0);
        run_req("load f3=3", 1, 0, 3'd3, 32'h8000_0000, 32'h0, 0);
        run_req("load+store", 1, 1, 3'd2, 32'h8000_0000, 32'h0, 0);
        run_req("neither", 0, 0, 3'd2, 32'h8000_0000, 32'h0, 0);
        run_req("sw f3=3", 0, 1, 3'd3, 32'h8000_0008, 32'h0, 0);

        // Long response stall
        run_req("lw stall5", 1, 0, 3'd2, 32'h8000_0014, 32'h0, 5);

        // Reset while the store is in its hold cycle
        wd = $urandom;
        @(negedge clk);
        chk("rst-hold req_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_load   = 1'b0;
        req_store  = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h8000_001D;
        req_wdata  = wd;
        exp_lanes(3'd0, 32'h8000_001D, wd, e_wd, e_wm);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst-hold wen en", 32'(mem_wen), 32'd1);
        @(negedge clk);
        chk("rst-hold wen hold", 32'(mem_wen), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst-hold wen", 32'(mem_wen), 32'd0);
        chk("rst-hold resp_valid", 32'(resp_valid), 32'd0);
        chk("rst-hold req_ready", 32'(req_ready), 32'd0);
        chk("rst-hold waddr", mem_waddr, 32'h8000_001C);
        chk("rst-hold wdata", mem_wdata, e_wd);
        chk("rst-hold wmask", 32'(mem_wmask), 32'(e_wm));
        rst = 1'b0;
        model_store(3'd0, 32'h8000_001D, wd);
        @(negedge clk);
        chk("rst-hold idle", 32'(req_ready), 32'd1);
        run_req("rst-hold readback", 1, 0, 3'd2, 32'h8000_001C, 32'h0, 0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            r = int'($urandom % 20);
            if (r == 0) begin
                ld = 1; st = 1;
            end else if (r == 1) begin
                ld = 0; st = 0;
            end else begin
                ld = ($urandom % 2) == 0;
                st = !ld;
            end
            f3 = st ? 3'($urandom % 4) : 3'($urandom % 8);
            a  = 32'h8000_0000 | ($urandom % 64);
            if (($urandom % 4) != 0 && f3[1:0] != 2'd3)
                a = a & ~(32'(nbytes(f3)) - 32'd1);
            run_req("rand", ld, st, f3, a, $urandom, int'($urandom % 4));
        end

        // Final sweep of every word through the load path
        for (int i = 0; i < 16; i++)
            run_req("sweep", 1, 0, 3'd2, 32'h8000_0000 | 32'(i * 4), 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
